// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: owns the PC and the FD/DE/EM/MW
// instruction, link-address and valid registers, and applies hazard-unit stall/flush
// controls and D-stage redirects. It also counts retirements and flags control misuse.
module pipe_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_instr,
    input  logic        stall_pc,
    input  logic        stall_fd,
    input  logic        flush_de,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] fd_instr,
    output logic [31:0] de_instr,
    output logic [31:0] em_instr,
    output logic [31:0] mw_instr,
    output logic [31:0] de_pc8,
    output logic [31:0] em_pc8,
    output logic [31:0] mw_pc8,
    output logic        fd_valid,
    output logic        de_valid,
    output logic        em_valid,
    output logic        mw_valid,
    output logic [31:0] retired_cnt,
    output logic        protocol_err
);

    localparam int unsigned XW = 32;

    logic [XW-1:0] pc_q, pc_d;
    logic [XW-1:0] fd_instr_q, fd_instr_d, fd_pc_q, fd_pc_d;
    logic          fd_valid_q, fd_valid_d;
    logic [XW-1:0] de_instr_q, de_instr_d, de_pc8_q, de_pc8_d;
    logic          de_valid_q, de_valid_d;
    logic [XW-1:0] em_instr_q, em_pc8_q, mw_instr_q, mw_pc8_q;
    logic          em_valid_q, mw_valid_q;
    logic [XW-1:0] retired_cnt_q, retired_cnt_d;
    logic          protocol_err_q, protocol_err_d;

    // Next-state for PC, FD and DE; stall outranks redirect, and the redirect never
    // touches FD, so the instruction fetched in the branch cycle is the delay slot.
    always_comb begin
        pc_d       = pc_q;
        fd_instr_d = fd_instr_q;
        fd_pc_d    = fd_pc_q;
        fd_valid_d = fd_valid_q;
        de_instr_d = fd_instr_q;
        de_pc8_d   = fd_pc_q + XW'(8);
        de_valid_d = fd_valid_q;

        if (!stall_pc) begin
            if (redirect_valid) pc_d = {redirect_pc[XW-1:2], 2'b00};
            else                pc_d = pc_q + XW'(4);
        end
        if (!stall_fd) begin
            fd_instr_d = imem_instr;
            fd_pc_d    = pc_q;
            fd_valid_d = 1'b1;
        end
        if (flush_de) begin
            de_instr_d = NOP_INSTR;
            de_pc8_d   = '0;
            de_valid_d = 1'b0;
        end
    end

    // Retirement count and sticky protocol-violation detection.
    always_comb begin
        retired_cnt_d  = retired_cnt_q;
        protocol_err_d = protocol_err_q;
        if (mw_valid_q) retired_cnt_d = retired_cnt_q + XW'(1);
        if (!((stall_pc == stall_fd) && (stall_fd == flush_de)))
            protocol_err_d = 1'b1;
        if (redirect_valid && !stall_pc && (redirect_pc[1:0] != 2'b00))
            protocol_err_d = 1'b1;
    end

    // All pipeline state; reset drops every stage at once without draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= RESET_PC;
            fd_instr_q     <= NOP_INSTR;
            fd_pc_q        <= '0;
            fd_valid_q     <= 1'b0;
            de_instr_q     <= NOP_INSTR;
            de_pc8_q       <= '0;
            de_valid_q     <= 1'b0;
            em_instr_q     <= NOP_INSTR;
            em_pc8_q       <= '0;
            em_valid_q     <= 1'b0;
            mw_instr_q     <= NOP_INSTR;
            mw_pc8_q       <= '0;
            mw_valid_q     <= 1'b0;
            retired_cnt_q  <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            fd_instr_q     <= fd_instr_d;
            fd_pc_q        <= fd_pc_d;
            fd_valid_q     <= fd_valid_d;
            de_instr_q     <= de_instr_d;
            de_pc8_q       <= de_pc8_d;
            de_valid_q     <= de_valid_d;
            em_instr_q     <= de_instr_q;
            em_pc8_q       <= de_pc8_q;
            em_valid_q     <= de_valid_q;
            mw_instr_q     <= em_instr_q;
            mw_pc8_q       <= em_pc8_q;
            mw_valid_q     <= em_valid_q;
            retired_cnt_q  <= retired_cnt_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign pc           = pc_q;
    assign fd_instr     = fd_instr_q;
    assign de_instr     = de_instr_q;
    assign em_instr     = em_instr_q;
    assign mw_instr     = mw_instr_q;
    assign de_pc8       = de_pc8_q;
    assign em_pc8       = em_pc8_q;
    assign mw_pc8       = mw_pc8_q;
    assign fd_valid     = fd_valid_q;
    assign de_valid     = de_valid_q;
    assign em_valid     = em_valid_q;
    assign mw_valid     = mw_valid_q;
    assign retired_cnt  = retired_cnt_q;
    assign protocol_err = protocol_err_q;

endmodule
